// File: rtl/pc_exc_unit_pkg.sv
// ============================================================================
// Module      : pc_exc_unit_pkg
// Description : Shared FSM state encoding, exception cause codes and vector
//               base default for the PC / exception unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_exc_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SAVE  = 2'd1,
        S_FETCH = 2'd2,
        S_LOAD  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'b00,
        CAUSE_BAD_OP = 2'b01,
        CAUSE_OVF    = 2'b10,
        CAUSE_DIV0   = 2'b11
    } cause_t;

    localparam logic [31:0] c_vec_base_default = 32'd253;
    localparam logic [31:0] c_pc_step          = 32'd4;

    // Cause codes start at 1, so the first vector sits at the base itself.
    function automatic logic [31:0] vec_addr_of(input logic [31:0] base,
                                                input cause_t      cause);
        return base + {30'b0, cause} - 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_exc_fsm.sv
// ============================================================================
// Module      : pc_exc_fsm
// Description : IDLE/SAVE/FETCH/LOAD sequencer producing PC/EPC load strobes
//               and the vector read. Branch strobes exist only when
//               PC_EXC_BRANCH_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_exc_fsm
    import pc_exc_unit_pkg::*;
#(
    parameter logic [31:0] VEC_BASE = c_vec_base_default
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic        cond_true,
    input  logic        exc_req,
    input  logic [1:0]  exc_cause,
    output logic        ld_next,
    output logic        save_epc,
    output logic        ld_vec,
    output logic        busy,
    output logic        vec_rd,
    output logic [31:0] vec_addr
`ifdef PC_EXC_BRANCH_STATS_EN
    ,
    output logic        br_taken,
    output logic        br_not_taken
`endif
);

    state_t r_state;
    state_t w_state_next;
    cause_t r_cause;
    cause_t w_cause_next;
    logic   w_br_taken;
    logic   w_br_not_taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cause <= CAUSE_NONE;
        end else begin
            r_state <= w_state_next;
            r_cause <= w_cause_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cause_next   = r_cause;
        ld_next        = 1'b0;
        save_epc       = 1'b0;
        ld_vec         = 1'b0;
        busy           = 1'b0;
        vec_rd         = 1'b0;
        vec_addr       = 32'd0;
        w_br_taken     = 1'b0;
        w_br_not_taken = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Priority: exception, then unconditional load, then branch.
                if (exc_req && (exc_cause != 2'b00)) begin
                    w_state_next = S_SAVE;
                    w_cause_next = cause_t'(exc_cause);
                end else if (pc_write) begin
                    ld_next = 1'b1;
                end else if (pc_write_cond) begin
                    if (cond_true) begin
                        ld_next    = 1'b1;
                        w_br_taken = 1'b1;
                    end else begin
                        w_br_not_taken = 1'b1;
                    end
                end
            end
            S_SAVE: begin
                busy         = 1'b1;
                save_epc     = 1'b1;
                w_state_next = S_FETCH;
            end
            S_FETCH: begin
                busy         = 1'b1;
                vec_rd       = 1'b1;
                vec_addr     = vec_addr_of(VEC_BASE, r_cause);
                w_state_next = S_LOAD;
            end
            S_LOAD: begin
                busy         = 1'b1;
                ld_vec       = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

`ifdef PC_EXC_BRANCH_STATS_EN
    assign br_taken     = w_br_taken;
    assign br_not_taken = w_br_not_taken;
`else
    logic w_br_unused;
    assign w_br_unused = w_br_taken ^ w_br_not_taken;
`endif

endmodule

`default_nettype wire

// File: rtl/pc_exc_unit.sv
// ============================================================================
// Module      : pc_exc_unit
// Description : Program counter with branch loads and a three-cycle exception
//               vector sequence. Define PC_EXC_BRANCH_STATS_EN for counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_exc_unit
    import pc_exc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] VEC_BASE = c_vec_base_default
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_write,
    input  logic        pc_write_cond,
    input  logic        cond_true,
    input  logic [31:0] next_pc,
    input  logic        exc_req,
    input  logic [1:0]  exc_cause,
    input  logic [7:0]  mem_rdata,
    output logic [31:0] pc,
    output logic [31:0] epc,
    output logic [31:0] vec_addr,
    output logic        vec_rd,
    output logic        busy
`ifdef PC_EXC_BRANCH_STATS_EN
    ,
    output logic [31:0] taken_count,
    output logic [31:0] not_taken_count
`endif
);

    logic        w_ld_next;
    logic        w_save_epc;
    logic        w_ld_vec;
    logic [31:0] r_pc;
    logic [31:0] r_epc;

`ifdef PC_EXC_BRANCH_STATS_EN
    logic        w_br_taken;
    logic        w_br_not_taken;
    logic [31:0] r_taken_count;
    logic [31:0] r_not_taken_count;
`endif

    pc_exc_fsm #(
        .VEC_BASE (VEC_BASE)
    ) u_fsm (
        .clk           (clk),
        .reset         (reset),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .cond_true     (cond_true),
        .exc_req       (exc_req),
        .exc_cause     (exc_cause),
        .ld_next       (w_ld_next),
        .save_epc      (w_save_epc),
        .ld_vec        (w_ld_vec),
        .busy          (busy),
        .vec_rd        (vec_rd),
        .vec_addr      (vec_addr)
`ifdef PC_EXC_BRANCH_STATS_EN
        ,
        .br_taken      (w_br_taken),
        .br_not_taken  (w_br_not_taken)
`endif
    );

    // pc has already advanced past the faulting instruction when SAVE runs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc  <= RESET_PC;
            r_epc <= 32'd0;
        end else begin
            if (w_ld_next) begin
                r_pc <= next_pc;
            end else if (w_ld_vec) begin
                r_pc <= {24'b0, mem_rdata};
            end
            if (w_save_epc) begin
                r_epc <= r_pc - c_pc_step;
            end
        end
    end

    assign pc  = r_pc;
    assign epc = r_epc;

`ifdef PC_EXC_BRANCH_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_taken_count     <= 32'd0;
            r_not_taken_count <= 32'd0;
        end else begin
            if (w_br_taken) begin
                r_taken_count <= r_taken_count + 32'd1;
            end
            if (w_br_not_taken) begin
                r_not_taken_count <= r_not_taken_count + 32'd1;
            end
        end
    end

    assign taken_count     = r_taken_count;
    assign not_taken_count = r_not_taken_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_exc_unit.sv
// ============================================================================
// Module      : tb_pc_exc_unit
// Description : Directed and random checks of pc_exc_unit against a
//               cycle-countdown reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_exc_unit;

    localparam logic [31:0] c_reset_pc = 32'h0000_0010;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_write;
    logic        pc_write_cond;
    logic        cond_true;
    logic [31:0] next_pc;
    logic        exc_req;
    logic [1:0]  exc_cause;
    logic [7:0]  mem_rdata;
    logic [31:0] pc;
    logic [31:0] epc;
    logic [31:0] vec_addr;
    logic        vec_rd;
    logic        busy;
`ifdef PC_EXC_BRANCH_STATS_EN
    logic [31:0] taken_count;
    logic [31:0] not_taken_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: m_cnt counts remaining busy cycles of an exception.
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    int          m_cnt;
    logic [1:0]  m_cause;
    logic [31:0] m_taken;
    logic [31:0] m_not_taken;

    pc_exc_unit #(
        .RESET_PC (c_reset_pc)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_write        (pc_write),
        .pc_write_cond   (pc_write_cond),
        .cond_true       (cond_true),
        .next_pc         (next_pc),
        .exc_req         (exc_req),
        .exc_cause       (exc_cause),
        .mem_rdata       (mem_rdata),
        .pc              (pc),
        .epc             (epc),
        .vec_addr        (vec_addr),
        .vec_rd          (vec_rd),
        .busy            (busy)
`ifdef PC_EXC_BRANCH_STATS_EN
        ,
        .taken_count     (taken_count),
        .not_taken_count (not_taken_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (reset) begin
            m_pc = c_reset_pc; m_epc = 32'd0; m_cnt = 0; m_cause = 2'b00;
            m_taken = 32'd0; m_not_taken = 32'd0;
        end else if (m_cnt > 0) begin
            if (m_cnt == 3) m_epc = m_pc - 32'd4;
            if (m_cnt == 1) m_pc = {24'd0, mem_rdata};
            m_cnt--;
        end else if (exc_req && exc_cause != 2'b00) begin
            m_cnt = 3; m_cause = exc_cause;
        end else if (pc_write) begin
            m_pc = next_pc;
        end else if (pc_write_cond) begin
            if (cond_true) begin m_pc = next_pc; m_taken++; end
            else m_not_taken++;
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check({tag, ".pc"}, pc, m_pc);
        check({tag, ".epc"}, epc, m_epc);
        check({tag, ".busy"}, {31'd0, busy}, {31'd0, m_cnt != 0});
        check({tag, ".vec_rd"}, {31'd0, vec_rd}, {31'd0, m_cnt == 2});
        check({tag, ".vec_addr"}, vec_addr, (m_cnt == 2) ? (32'd252 + {30'd0, m_cause}) : 32'd0);
`ifdef PC_EXC_BRANCH_STATS_EN
        check({tag, ".taken"}, taken_count, m_taken);
        check({tag, ".not_taken"}, not_taken_count, m_not_taken);
`endif
    endtask

    task automatic idle_inputs();
        reset = 1'b0; pc_write = 1'b0; pc_write_cond = 1'b0; cond_true = 1'b0;
        next_pc = 32'd0; exc_req = 1'b0; exc_cause = 2'b00; mem_rdata = 8'd0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        tick("reset");
        check("reset_pc", pc, 32'h0000_0010);
        check("reset_epc", epc, 32'd0);

        // Unconditional load
        idle_inputs(); pc_write = 1'b1; next_pc = 32'h40;
        tick("pcw");
        check("pcw_pc", pc, 32'h40);
        check("pcw_busy", {31'd0, busy}, 32'd0);

        // Conditional load: not taken, then taken
        idle_inputs(); pc_write_cond = 1'b1; next_pc = 32'h80; cond_true = 1'b0;
        tick("br_nt");
        check("br_nt_pc", pc, 32'h40);
        cond_true = 1'b1;
        tick("br_t");
        check("br_t_pc", pc, 32'h80);
`ifdef PC_EXC_BRANCH_STATS_EN
        check("br_taken1", taken_count, 32'd1);
        check("br_not_taken1", not_taken_count, 32'd1);
`endif

        // Overflow exception from pc=0x104
        idle_inputs(); pc_write = 1'b1; next_pc = 32'h104;
        tick("set104");
        idle_inputs(); exc_req = 1'b1; exc_cause = 2'b10;
        tick("ovf_acc");
        check("ovf_busy_save", {31'd0, busy}, 32'd1);
        idle_inputs(); pc_write = 1'b1; next_pc = 32'hDEAD_0000;
        tick("ovf_fetch");
        check("ovf_epc", epc, 32'h100);
        check("ovf_vec_rd", {31'd0, vec_rd}, 32'd1);
        check("ovf_vec_addr", vec_addr, 32'd254);
        mem_rdata = 8'h3C;
        tick("ovf_load");
        check("ovf_busy_load", {31'd0, busy}, 32'd1);
        check("ovf_vec_rd_load", {31'd0, vec_rd}, 32'd0);
        idle_inputs(); mem_rdata = 8'h3C;
        tick("ovf_done");
        check("ovf_pc", pc, 32'h3C);
        check("ovf_busy_done", {31'd0, busy}, 32'd0);

        // Exception beats pc_write in the same cycle
        idle_inputs(); exc_req = 1'b1; exc_cause = 2'b01; pc_write = 1'b1; next_pc = 32'h500;
        tick("prio_acc");
        check("prio_pc", pc, 32'h3C);
        idle_inputs();
        tick("prio_save");
        check("prio_vec_addr", vec_addr, 32'd253);

        // Reset during FETCH aborts the sequence
        reset = 1'b1;
        tick("rst_fetch");
        check("rst_fetch_pc", pc, 32'h0000_0010);
        check("rst_fetch_epc", epc, 32'd0);
        check("rst_fetch_busy", {31'd0, busy}, 32'd0);
        idle_inputs(); exc_req = 1'b1; exc_cause = 2'b00;
        tick("cause00");
        check("cause00_busy", {31'd0, busy}, 32'd0);

        // Divide-by-zero from pc=0: epc wraps
        idle_inputs(); pc_write = 1'b1; next_pc = 32'h0;
        tick("set0");
        idle_inputs(); exc_req = 1'b1; exc_cause = 2'b11;
        tick("dz_acc");
        idle_inputs();
        tick("dz_fetch");
        check("dz_epc", epc, 32'hFFFF_FFFC);
        check("dz_vec_addr", vec_addr, 32'd255);
        tick("dz_load");
        tick("dz_done");

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            reset         = ($urandom_range(0, 49) == 0);
            exc_req       = ($urandom_range(0, 5) == 0);
            exc_cause     = 2'($urandom_range(0, 3));
            pc_write      = ($urandom_range(0, 3) == 0);
            pc_write_cond = ($urandom_range(0, 1) == 1);
            cond_true     = ($urandom_range(0, 1) == 1);
            next_pc       = $urandom;
            mem_rdata     = 8'($urandom);
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
